// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a skid-buffered output stage
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int W = XLEN + 4;
    logic [2:0] dec_fmt;
    logic [31:0] dec_raw;
    logic [W-1:0] dec, out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d, skid_full_q, skid_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic in_fire, out_fire;
    always_comb begin
        case (inst[6:0])
            7'h13, 7'h03, 7'h67: dec_fmt = 3'd1;
            7'h1b:               dec_fmt = XLEN == 64 ? 3'd1 : 3'd7;
            7'h23:               dec_fmt = 3'd2;
            7'h63:               dec_fmt = 3'd3;
            7'h37, 7'h17:        dec_fmt = 3'd4;
            7'h6f:               dec_fmt = 3'd5;
            7'h33:               dec_fmt = 3'd0;
            7'h3b:               dec_fmt = XLEN == 64 ? 3'd0 : 3'd7;
            default:             dec_fmt = 3'd7;
        endcase
        case (dec_fmt)
            3'd1:    dec_raw = 32'($signed(inst[31:20]));
            3'd2:    dec_raw = 32'($signed({inst[31:25], inst[11:7]}));
            3'd3:    dec_raw = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            3'd4:    dec_raw = {inst[31:12], 12'b0};
            3'd5:    dec_raw = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: dec_raw = '0;
        endcase
        dec = {dec_fmt == 3'd7, dec_fmt, XLEN'($signed(dec_raw))};
    end
    assign in_ready = !skid_full_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        cnt_d       = (in_fire && dec_fmt == 3'd7 && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        if (out_fire && skid_full_q) begin
            out_d       = skid_q;
            skid_full_d = 1'b0;
        end else if (in_fire && (out_fire || !out_valid_q)) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (in_fire) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            cnt_q       <= cnt_d;
        end
    end
    assign out_valid   = out_valid_q;
    assign imm         = out_q[XLEN-1:0];
    assign fmt         = out_q[XLEN+2:XLEN];
    assign illegal     = out_q[XLEN+3];
    assign illegal_cnt = cnt_q;
endmodule
